// File: rtl/result_display_driver_if.sv
// Load/result handshake between the calculator datapath and the display driver.
interface result_display_driver_if;
    logic [7:0]  result;
    logic        load;
    logic        ready;
    logic        done;
    logic        sign_out;
    logic [11:0] bcd_out;

    // Datapath side: presents a result and requests conversion.
    modport master (
        output result,
        output load,
        input  ready,
        input  done,
        input  sign_out,
        input  bcd_out
    );

    // Display driver side: accepts a result and reports the converted digits.
    modport slave (
        input  result,
        input  load,
        output ready,
        output done,
        output sign_out,
        output bcd_out
    );
endinterface

// File: rtl/result_display_driver.sv
// Two's-complement result -> sign-magnitude -> 3-digit BCD (serial double dabble),
// shown on a 4-position multiplexed active-low 7-segment display.
module result_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned LZ_BLANK    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    result_display_driver_if.slave        bus,
    output logic [3:0]                    an,
    output logic [6:0]                    seg
);

    localparam int unsigned PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned BCD_W    = 12;
    localparam int unsigned MAG_W    = 8;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               sign_out_q, sign_out_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic [BCD_W-1:0]   adj_c;
    logic [BCD_W+MAG_W-1:0] shifted_c;

    logic [PW-1:0]      presc_q;
    logic [1:0]         scan_idx_q;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    // Active-low 7-segment pattern for one BCD digit; out-of-range nibbles blank.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to each nibble that is 5 or more.
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

    assign accept_c  = bus.load && ready_q;
    assign adj_c     = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};
    assign shifted_c = {adj_c[BCD_W-2:0], mag_q, 1'b0};

    // Conversion FSM and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            scratch_q  <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            bcd_out_q  <= '0;
            sign_out_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scratch_q  <= scratch_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            bcd_out_q  <= bcd_out_d;
            sign_out_q <= sign_out_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // Next state; registered outputs are computed for the state being entered,
    // so done/ready/digits are visible throughout the DONE cycle.
    always_comb begin
        state_d    = state_q;
        scratch_d  = scratch_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        bcd_out_d  = bcd_out_q;
        sign_out_d = sign_out_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                ready_d = 1'b1;
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
                if (accept_c) begin
                    sign_d    = bus.result[7];
                    mag_d     = bus.result[7] ? 8'(~bus.result + 8'd1) : bus.result;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ready_d   = 1'b0;
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                ready_d   = 1'b0;
                scratch_d = shifted_c[BCD_W+MAG_W-1:MAG_W];
                mag_d     = shifted_c[MAG_W-1:0];
                cnt_d     = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(7)) begin
                    state_d    = ST_DONE;
                    bcd_out_d  = shifted_c[BCD_W+MAG_W-1:MAG_W];
                    sign_out_d = sign_q;
                    done_d     = 1'b1;
                    ready_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.sign_out = sign_out_q;
    assign bus.bcd_out  = bcd_out_q;

    // Scan prescaler, position index and registered digit drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            scan_idx_q <= '0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_BLANK;
        end else begin
            if (presc_q == PW'(REFRESH_DIV - 1)) begin
                presc_q    <= '0;
                scan_idx_q <= 2'(scan_idx_q + 2'd1);
            end else begin
                presc_q <= PW'(presc_q + PW'(1));
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    // Digit selection with optional leading-zero blanking.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        case (scan_idx_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg_code(bcd_out_q[3:0]);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = ((LZ_BLANK != 0) && (bcd_out_q[11:8] == 4'd0) && (bcd_out_q[7:4] == 4'd0))
                        ? SEG_BLANK : seg_code(bcd_out_q[7:4]);
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = ((LZ_BLANK != 0) && (bcd_out_q[11:8] == 4'd0))
                        ? SEG_BLANK : seg_code(bcd_out_q[11:8]);
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = sign_out_q ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
